// File: rtl/mem_2r2w_arb.sv
// mem_2r2w_arb: round-robin arbiter sharing one 2R2W memory among NC clients.
// Optional same-address write deferral: define MEM_2R2W_ARB_WW_COLLIDE_EN.
module mem_2r2w_arb #(
  parameter int NC      = 4,
  parameter int AW      = 10,
  parameter int DW      = 32,
  parameter int WORDS   = 1024,
  parameter int LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NC-1:0]    req_vld,
  input  logic [NC-1:0]    req_wr,
  input  logic [NC*AW-1:0] req_addr,
  input  logic [NC*DW-1:0] req_din,
  input  logic [NC*DW-1:0] req_bw,
  output logic [NC-1:0]    req_rdy,
  output logic [NC-1:0]    rsp_vld,
  output logic [NC*DW-1:0] rsp_data,
  output logic             m_read_0,
  output logic             m_read_1,
  output logic [AW-1:0]    m_addr_0,
  output logic [AW-1:0]    m_addr_1,
  input  logic [DW-1:0]    m_dout_0,
  input  logic [DW-1:0]    m_dout_1,
  output logic             m_write_2,
  output logic             m_write_3,
  output logic [AW-1:0]    m_addr_2,
  output logic [AW-1:0]    m_addr_3,
  output logic [DW-1:0]    m_bw_2,
  output logic [DW-1:0]    m_bw_3,
  output logic [DW-1:0]    m_din_2,
  output logic [DW-1:0]    m_din_3,
  output logic             err_addr
);

  localparam int PW = (NC > 1) ? $clog2(NC) : 1;

  logic [AW-1:0] ra [NC];
  logic [DW-1:0] wd [NC];
  logic [DW-1:0] wb [NC];
  logic [DW-1:0] rdat [NC];

  logic [NC-1:0] in_rng;
  logic [NC-1:0] rd_elig, wr_elig;
  logic [NC-1:0] rd_gnt, wr_gnt;

  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [PW-1:0] rd_c0, rd_c1, wr_c0, wr_c1;
  logic [PW-1:0] rc, wc;
  logic          rd_g0, rd_g1, wr_g0, wr_g1;

  logic [LATENCY-1:0] t0_v, t1_v;
  logic [PW-1:0]      t0_id [LATENCY];
  logic [PW-1:0]      t1_id [LATENCY];

  for (genvar g = 0; g < NC; g++) begin : g_cli
    assign ra[g] = req_addr[g*AW +: AW];
    assign wd[g] = req_din[g*DW +: DW];
    assign wb[g] = req_bw[g*DW +: DW];
    assign rsp_data[g*DW +: DW] = rdat[g];
    if (64'(WORDS) < (64'd1 << AW)) begin : g_chk
      assign in_rng[g] = ra[g] < AW'(WORDS);
    end else begin : g_all
      assign in_rng[g] = 1'b1;
    end
  end

  // (p + i) mod NC without a divider
  function automatic logic [PW-1:0] wrap(
    input logic [PW-1:0] p,
    input int            i
  );
    logic [PW:0] s;
    s = {1'b0, p} + (PW+1)'(i);
    if (s >= (PW+1)'(NC)) s = s - (PW+1)'(NC);
    return s[PW-1:0];
  endfunction

  assign rd_elig = req_vld & ~req_wr & in_rng & {NC{rst}};
  assign wr_elig = req_vld &  req_wr & in_rng & {NC{rst}};
  assign req_rdy = rd_gnt | wr_gnt;

  always_comb begin
    rd_gnt = '0;
    rd_g0  = 1'b0;
    rd_g1  = 1'b0;
    rd_c0  = '0;
    rd_c1  = '0;
    rc     = '0;
    for (int i = 0; i < NC; i++) begin
      rc = wrap(rd_ptr, i);
      if (rd_elig[rc] && !rd_g0) begin
        rd_g0      = 1'b1;
        rd_c0      = rc;
        rd_gnt[rc] = 1'b1;
      end else if (rd_elig[rc] && !rd_g1) begin
        rd_g1      = 1'b1;
        rd_c1      = rc;
        rd_gnt[rc] = 1'b1;
      end
    end
  end

  always_comb begin
    wr_gnt = '0;
    wr_g0  = 1'b0;
    wr_g1  = 1'b0;
    wr_c0  = '0;
    wr_c1  = '0;
    wc     = '0;
    for (int i = 0; i < NC; i++) begin
      wc = wrap(wr_ptr, i);
      if (wr_elig[wc] && !wr_g0) begin
        wr_g0      = 1'b1;
        wr_c0      = wc;
        wr_gnt[wc] = 1'b1;
`ifdef MEM_2R2W_ARB_WW_COLLIDE_EN
      end else if (wr_elig[wc] && !wr_g1 &&
                   ra[wc] != ra[wr_c0]) begin
`else
      end else if (wr_elig[wc] && !wr_g1) begin
`endif
        wr_g1      = 1'b1;
        wr_c1      = wc;
        wr_gnt[wc] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      m_read_0  <= 1'b0;
      m_read_1  <= 1'b0;
      m_write_2 <= 1'b0;
      m_write_3 <= 1'b0;
      m_addr_0  <= '0;
      m_addr_1  <= '0;
      m_addr_2  <= '0;
      m_addr_3  <= '0;
      m_bw_2    <= '0;
      m_bw_3    <= '0;
      m_din_2   <= '0;
      m_din_3   <= '0;
      err_addr  <= 1'b0;
      rsp_vld   <= '0;
      t0_v      <= '0;
      t1_v      <= '0;
      for (int s = 0; s < LATENCY; s++) begin
        t0_id[s] <= '0;
        t1_id[s] <= '0;
      end
      for (int c = 0; c < NC; c++) rdat[c] <= '0;
    end else begin
      if (rd_g1)      rd_ptr <= wrap(rd_c1, 1);
      else if (rd_g0) rd_ptr <= wrap(rd_c0, 1);
      if (wr_g1)      wr_ptr <= wrap(wr_c1, 1);
      else if (wr_g0) wr_ptr <= wrap(wr_c0, 1);

      m_read_0  <= rd_g0;
      m_read_1  <= rd_g1;
      m_write_2 <= wr_g0;
      m_write_3 <= wr_g1;
      if (rd_g0) m_addr_0 <= ra[rd_c0];
      if (rd_g1) m_addr_1 <= ra[rd_c1];
      if (wr_g0) begin
        m_addr_2 <= ra[wr_c0];
        m_bw_2   <= wb[wr_c0];
        m_din_2  <= wd[wr_c0];
      end
      if (wr_g1) begin
        m_addr_3 <= ra[wr_c1];
        m_bw_3   <= wb[wr_c1];
        m_din_3  <= wd[wr_c1];
      end

      if (|(req_vld & ~in_rng)) err_addr <= 1'b1;

      // tag stage 0 runs alongside the strobe; rsp regs are the last stage
      t0_v[0]  <= rd_g0;
      t1_v[0]  <= rd_g1;
      t0_id[0] <= rd_c0;
      t1_id[0] <= rd_c1;
      for (int s = 1; s < LATENCY; s++) begin
        t0_v[s]  <= t0_v[s-1];
        t1_v[s]  <= t1_v[s-1];
        t0_id[s] <= t0_id[s-1];
        t1_id[s] <= t1_id[s-1];
      end

      rsp_vld <= '0;
      for (int c = 0; c < NC; c++) begin
        if (t0_v[LATENCY-1] && t0_id[LATENCY-1] == PW'(c)) begin
          rsp_vld[c] <= 1'b1;
          rdat[c]    <= m_dout_0;
        end
        if (t1_v[LATENCY-1] && t1_id[LATENCY-1] == PW'(c)) begin
          rsp_vld[c] <= 1'b1;
          rdat[c]    <= m_dout_1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_2r2w_arb.sv
// tb_mem_2r2w_arb: directed bench for mem_2r2w_arb with a 2R2W memory model.
// Collision expectations follow MEM_2R2W_ARB_WW_COLLIDE_EN.
module tb_mem_2r2w_arb;

  localparam int NC  = 4;
  localparam int AW  = 11;
  localparam int DW  = 32;
  localparam int WDS = 1024;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [NC-1:0]    req_vld, req_wr, req_rdy, rsp_vld;
  logic [NC*AW-1:0] req_addr;
  logic [NC*DW-1:0] req_din, req_bw, rsp_data;
  logic             m_read_0, m_read_1, m_write_2, m_write_3;
  logic [AW-1:0]    m_addr_0, m_addr_1, m_addr_2, m_addr_3;
  logic [DW-1:0]    m_dout_0, m_dout_1;
  logic [DW-1:0]    m_bw_2, m_bw_3, m_din_2, m_din_3;
  logic             err_addr;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] mem [2048];
  logic [DW-1:0] q0, q1;
  logic          pre_en = 1'b0;
  logic [AW-1:0] pre_a  = '0;
  logic [DW-1:0] pre_d  = '0;

  mem_2r2w_arb #(
    .NC(NC), .AW(AW), .DW(DW), .WORDS(WDS), .LATENCY(LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_vld(req_vld), .req_wr(req_wr), .req_addr(req_addr),
    .req_din(req_din), .req_bw(req_bw), .req_rdy(req_rdy),
    .rsp_vld(rsp_vld), .rsp_data(rsp_data),
    .m_read_0(m_read_0), .m_read_1(m_read_1),
    .m_addr_0(m_addr_0), .m_addr_1(m_addr_1),
    .m_dout_0(m_dout_0), .m_dout_1(m_dout_1),
    .m_write_2(m_write_2), .m_write_3(m_write_3),
    .m_addr_2(m_addr_2), .m_addr_3(m_addr_3),
    .m_bw_2(m_bw_2), .m_bw_3(m_bw_3),
    .m_din_2(m_din_2), .m_din_3(m_din_3),
    .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  // memory: strobe sampled at an edge, data visible the next cycle
  always @(posedge clk) begin
    if (m_read_0) q0 <= mem[m_addr_0];
    if (m_read_1) q1 <= mem[m_addr_1];
    if (pre_en) mem[pre_a] <= pre_d;
    if (m_write_2)
      mem[m_addr_2] <= (mem[m_addr_2] & ~m_bw_2) | (m_din_2 & m_bw_2);
    if (m_write_3)
      mem[m_addr_3] <= (mem[m_addr_3] & ~m_bw_3) | (m_din_3 & m_bw_3);
  end
  assign m_dout_0 = q0;
  assign m_dout_1 = q1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    req_vld  = '0;
    req_wr   = '0;
    req_addr = '0;
    req_din  = '0;
    req_bw   = '0;
  endtask

  task automatic rd(input int c, input int a);
    req_vld[c] = 1'b1;
    req_wr[c]  = 1'b0;
    req_addr[c*AW +: AW] = AW'(a);
  endtask

  task automatic wr(input int c, input int a, input logic [31:0] d);
    req_vld[c] = 1'b1;
    req_wr[c]  = 1'b1;
    req_addr[c*AW +: AW] = AW'(a);
    req_din[c*DW +: DW]  = d;
    req_bw[c*DW +: DW]   = '1;
  endtask

  function automatic logic [31:0] rdat(input int c);
    return rsp_data[c*DW +: DW];
  endfunction

  initial begin
    idle();
    rst = 1'b0;
    pre_en = 1'b1;
    for (int a = 0; a < 16; a++) begin
      pre_a = AW'(a);
      pre_d = 32'hC0DE0000 | 32'(a);
      tick();
    end
    pre_a = 11'd5;
    pre_d = 32'hA5A5A5A5;
    tick();
    pre_en = 1'b0;

    // reset state with requests pending
    for (int c = 0; c < NC; c++) rd(c, c);
    #1;
    chk("rst_rdy", 64'(req_rdy), 0);
    chk("rst_m_read_0", 64'(m_read_0), 0);
    chk("rst_m_write_2", 64'(m_write_2), 0);
    chk("rst_rsp_vld", 64'(rsp_vld), 0);
    chk("rst_err", 64'(err_addr), 0);
    chk("rst_m_addr_0", 64'(m_addr_0), 0);
    chk("rst_m_din_2", 64'(m_din_2), 0);
    chk("rst_rsp_data", 64'(|rsp_data), 0);
    idle();
    rst = 1'b1;
    tick();

    // single read
    rd(2, 5);
    #1;
    chk("t1_rdy", 64'(req_rdy), 64'b0100);
    tick();
    idle();
    chk("t1_m_read_0", 64'(m_read_0), 1);
    chk("t1_m_addr_0", 64'(m_addr_0), 5);
    chk("t1_m_read_1", 64'(m_read_1), 0);
    tick();
    chk("t1_rsp_early", 64'(rsp_vld), 0);
    tick();
    chk("t1_rsp_vld", 64'(rsp_vld), 64'b0100);
    chk("t1_rsp_data", 64'(rdat(2)), 64'hA5A5A5A5);
    tick();
    chk("t1_rsp_once", 64'(rsp_vld), 0);

    // reset mid-flight (rd_ptr is 3 here)
    rd(1, 6);
    #1;
    chk("rf_rdy", 64'(req_rdy), 64'b0010);
    tick();
    idle();
    rst = 1'b0;
    chk("rf_m_read_0", 64'(m_read_0), 1);
    tick();
    rst = 1'b1;
    chk("rf_m_read_clr", 64'(m_read_0), 0);
    tick();
    chk("rf_rsp_t3", 64'(rsp_vld), 0);
    tick();
    chk("rf_rsp_t4", 64'(rsp_vld), 0);

    // saturation: pointers restart at 0
    for (int c = 0; c < NC; c++) rd(c, 10 + c);
    #1;
    for (int k = 0; k < 6; k++) begin
      chk("sat_rdy", 64'(req_rdy), (k % 2 == 0) ? 64'b0011 : 64'b1100);
      tick();
      chk("sat_addr0", 64'(m_addr_0), (k % 2 == 0) ? 10 : 12);
      chk("sat_addr1", 64'(m_addr_1), (k % 2 == 0) ? 11 : 13);
      if (k >= 2) begin
        chk("sat_rsp_vld", 64'(rsp_vld),
            (k % 2 == 0) ? 64'b0011 : 64'b1100);
        chk("sat_data_lo", 64'(rdat((k % 2 == 0) ? 0 : 2)),
            (k % 2 == 0) ? 64'hC0DE000A : 64'hC0DE000C);
        chk("sat_data_hi", 64'(rdat((k % 2 == 0) ? 1 : 3)),
            (k % 2 == 0) ? 64'hC0DE000B : 64'hC0DE000D);
      end
    end
    idle();
    tick();
    chk("sat_tail4", 64'(rsp_vld), 64'b0011);
    tick();
    chk("sat_tail5", 64'(rsp_vld), 64'b1100);
    tick();
    chk("sat_drain", 64'(rsp_vld), 0);

    // mixed: two writes and two reads in one cycle
    wr(0, 1, 32'h11);
    wr(1, 2, 32'h22);
    rd(2, 3);
    rd(3, 4);
    #1;
    chk("mx_rdy", 64'(req_rdy), 64'b1111);
    tick();
    idle();
    chk("mx_w2", 64'({m_write_2, m_addr_2, m_din_2}), {1'b1, 11'd1, 32'h11});
    chk("mx_w3", 64'({m_write_3, m_addr_3, m_din_3}), {1'b1, 11'd2, 32'h22});
    chk("mx_bw2", 64'(m_bw_2), 64'hFFFFFFFF);
    chk("mx_r0", 64'({m_read_0, m_addr_0}), {1'b1, 11'd3});
    chk("mx_r1", 64'({m_read_1, m_addr_1}), {1'b1, 11'd4});
    rd(0, 1);
    rd(1, 2);
    #1;
    chk("mx2_rdy", 64'(req_rdy), 64'b0011);
    tick();
    idle();
    wr(2, 3, 32'h33);
    rd(3, 3);
    #1;
    chk("mx3_rdy", 64'(req_rdy), 64'b1100);
    tick();
    idle();
    chk("mx1_rsp_vld", 64'(rsp_vld), 64'b1100);
    chk("mx1_d2", 64'(rdat(2)), 64'hC0DE0003);
    chk("mx1_d3", 64'(rdat(3)), 64'hC0DE0004);
    tick();
    chk("mx2_rsp_vld", 64'(rsp_vld), 64'b0011);
    chk("mx2_d0", 64'(rdat(0)), 64'h11);
    chk("mx2_d1", 64'(rdat(1)), 64'h22);
    tick();
    chk("mx3_rsp_vld", 64'(rsp_vld), 64'b1000);
    chk("mx3_old", 64'(rdat(3)), 64'hC0DE0003);
    chk("mx3_hold", 64'(rdat(2)), 64'hC0DE0003);
    rd(3, 3);
    #1;
    chk("mx4_rdy", 64'(req_rdy), 64'b1000);
    tick();
    idle();
    tick();
    tick();
    chk("mx4_rsp_vld", 64'(rsp_vld), 64'b1000);
    chk("mx4_new", 64'(rdat(3)), 64'h33);

    // collision on addr 7; first move wr_ptr to 1
    wr(0, 8, 32'h88);
    #1;
    chk("col_pre_rdy", 64'(req_rdy), 64'b0001);
    tick();
    idle();
    wr(1, 7, 32'h1111);
    wr(3, 7, 32'h3333);
    #1;
`ifdef MEM_2R2W_ARB_WW_COLLIDE_EN
    chk("col_rdy", 64'(req_rdy), 64'b0010);
    tick();
    req_vld[1] = 1'b0;
    #1;
    chk("col_w2", 64'({m_write_2, m_addr_2, m_din_2}), {1'b1, 11'd7, 32'h1111});
    chk("col_w3", 64'(m_write_3), 0);
    chk("col_retry_rdy", 64'(req_rdy), 64'b1000);
    tick();
    idle();
    chk("col_w2b", 64'({m_write_2, m_addr_2, m_din_2}), {1'b1, 11'd7, 32'h3333});
    rd(2, 7);
    #1;
    chk("col_rd_rdy", 64'(req_rdy), 64'b0100);
    tick();
    idle();
    tick();
    tick();
    chk("col_rsp_vld", 64'(rsp_vld), 64'b0100);
    chk("col_mem7", 64'(rdat(2)), 64'h3333);
`else
    chk("col_rdy", 64'(req_rdy), 64'b1010);
    tick();
    idle();
    chk("col_w2", 64'({m_write_2, m_addr_2, m_din_2}), {1'b1, 11'd7, 32'h1111});
    chk("col_w3", 64'({m_write_3, m_addr_3, m_din_3}), {1'b1, 11'd7, 32'h3333});
`endif
    tick();

    // out-of-range address
    chk("rng_err_pre", 64'(err_addr), 0);
    rd(0, 1024);
    rd(1, 9);
    #1;
    chk("rng_rdy", 64'(req_rdy), 64'b0010);
    chk("rng_err_now", 64'(err_addr), 0);
    tick();
    req_vld[1] = 1'b0;
    #1;
    chk("rng_err_set", 64'(err_addr), 1);
    chk("rng_stall", 64'(req_rdy), 0);
    tick();
    chk("rng_stall2", 64'(req_rdy), 0);
    idle();
    tick();
    chk("rng_sticky", 64'(err_addr), 1);
    rst = 1'b0;
    tick();
    chk("rng_err_clr", 64'(err_addr), 0);
    rd(2, 3);
    #1;
    chk("rng_rst_rdy", 64'(req_rdy), 0);
    idle();
    rst = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_2r2w_arb.md
# mem_2r2w_arb

Round-robin arbiter sharing one 2-read/2-write memory among NC requesters. Each cycle it accepts up to two reads and two writes, drives them onto the memory ports as registered commands, and returns read data to the issuing requester through a latency-matched tag pipeline. It sits between client pipelines and a 2R2W memory macro or behavioral model.

## Interface
- NC, 4, number of requesters (2..8)
- AW, 10, address width
- DW, 32, data width
- WORDS, 1024, memory depth; requests with addr >= WORDS are never accepted
- LATENCY, 2, memory read latency in cycles (1..29)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- req_vld  in  NC  request valid per client
- req_wr  in  NC  1 = write, 0 = read
- req_addr  in  NC*AW  packed addresses, client c at [c*AW +: AW]
- req_din  in  NC*DW  packed write data
- req_bw  in  NC*DW  packed bit-write enables
- req_rdy  out  NC  accept; transfer when req_vld & req_rdy
- rsp_vld  out  NC  read response valid per client
- rsp_data  out  NC*DW  packed read data
- m_read_0, m_read_1  out  1  memory read strobes
- m_addr_0, m_addr_1  out  AW  memory read addresses
- m_dout_0, m_dout_1  in  DW  memory read data
- m_write_2, m_write_3  out  1  memory write strobes
- m_addr_2, m_addr_3  out  AW  memory write addresses
- m_bw_2, m_bw_3  out  DW  memory bit-write enables
- m_din_2, m_din_3  out  DW  memory write data
- err_addr  out  1  sticky: a request with addr >= WORDS was presented

## Operation
- Reads and writes arbitrate independently; a client presents one request per cycle.
- Read arbitration: scan clients from rd_ptr upward, wrapping; first eligible read -> port 0, second -> port 1. Writes likewise from wr_ptr -> ports 2, 3.
- req_rdy is combinational from the current requests and pointers.
- Pointer update: rd_ptr/wr_ptr <= (last granted client + 1) mod NC; unchanged if nothing is granted.
- Accepted commands are registered into m_* outputs. Strobes deasserted: addr/bw/din hold their last values.
- Tag pipeline per read port, depth LATENCY+1: {valid, client id}. At the output stage: rsp_vld[id] <= 1 and rsp_data[id] <= m_dout_p. Other clients' rsp_data hold.
- Out-of-range request: never granted, err_addr set until reset. The client stalls forever; error handling is the client's responsibility.
- Read and write to the same address accepted in the same cycle: the read returns the old data.
- No response backpressure: clients must always sink rsp_vld.

## Timing
- Request accepted at edge T: m_* strobe high in cycle T+1; rsp_vld high for one cycle in cycle T+1+LATENCY.
- Full throughput: 2 reads + 2 writes per cycle, no bubbles.
- Reset: while rst = 0, req_rdy = 0. At the edge sampling rst = 0:
  - rd_ptr, wr_ptr <= 0.
  - All tag valids, m_read_*, m_write_*, rsp_vld, err_addr <= 0.
  - m_addr_*, m_bw_*, m_din_*, rsp_data <= 0.
- Reset mid-operation discards in-flight reads: no rsp_vld is produced for them, even after rst returns high.

## Configuration
- MEM_2R2W_ARB_WW_COLLIDE_EN defined:
  - If the second write candidate's address equals the first's, the second is not granted that cycle; scanning continues for a further non-colliding writer.
  - The deferred client keeps req_rdy = 0 and retries next cycle.
- Undefined: no address comparison. Same-address writes may both be granted, and the final memory content is undefined. Clients must guarantee this never happens.

## Test plan
- Single read: reset, preload mem[5] = 0xA5A5A5A5; client 2 reads addr 5 at T -> m_read_0 at T+1, rsp_vld[2] = 1 with 0xA5A5A5A5 at T+3 (LATENCY = 2), all other rsp_vld = 0.
- Saturation: all 4 clients read continuously -> grants {0,1}, {2,3}, {0,1}…, two responses every cycle, and each rsp_data matches its own address.
- Mixed: clients 0, 1 write addrs 1, 2 (bw all-ones, din 0x11, 0x22) while clients 2, 3 read addrs 3, 4 in the same cycle -> all four req_rdy = 1. A subsequent read of addrs 1, 2 returns 0x11 and 0x22.
- Collision (macro defined): clients 1 and 3 both write addr 7 in cycle T -> only client 1 is granted at T, client 3 at T+1, and mem[7] ends at client 3's data. With the macro undefined, both are granted at T.
- Reset mid-flight: read accepted at T, rst = 0 at T+1 for one cycle -> no rsp_vld at T+3, pointers back at 0, and the next accepted read returns normally.
- Range error: client 0 requests addr 1024 -> req_rdy[0] stays 0, err_addr = 1 from the next cycle until reset.
